// File: rtl/ddr_rd_line_fetch.sv
// Frame fetcher: issues per-line DDR burst reads, buffers returned beats in a circular
// RAM and streams them out over a valid/ready pixel interface with line/frame markers.
module ddr_rd_line_fetch #(
    parameter int unsigned g_BUFF_AWIDTH = 10,
    parameter int unsigned g_DWIDTH      = 64,
    parameter int unsigned g_DDR_AWIDTH  = 32,
    parameter int unsigned g_BURST_LEN   = 16
) (
    input  logic                    sys_clk_i,
    input  logic                    resetn_i,
    input  logic                    frame_start_i,
    input  logic [g_DDR_AWIDTH-1:0] frame_base_addr_i,
    input  logic [g_DDR_AWIDTH-1:0] line_stride_i,
    input  logic [15:0]             line_beats_i,
    input  logic [11:0]             frame_lines_i,
    output logic                    rd_req_o,
    input  logic                    rd_ack_i,
    output logic [g_DDR_AWIDTH-1:0] rd_addr_o,
    output logic [8:0]              rd_len_o,
    input  logic                    rd_data_valid_i,
    input  logic [g_DWIDTH-1:0]     rd_data_i,
    output logic                    pix_valid_o,
    input  logic                    pix_ready_i,
    output logic [g_DWIDTH-1:0]     pix_data_o,
    output logic                    line_end_o,
    output logic                    frame_end_o,
    output logic                    busy_o,
    output logic                    ovf_err_o
);

    localparam int unsigned CW = g_BUFF_AWIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(2 ** g_BUFF_AWIDTH);
    localparam logic [g_DDR_AWIDTH-1:0] BEAT_BYTES = g_DDR_AWIDTH'(g_DWIDTH / 8);
    localparam logic [15:0] BURST16 = 16'(g_BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t                   state;
    logic [g_DDR_AWIDTH-1:0]  cfg_stride;
    logic [g_DDR_AWIDTH-1:0]  line_addr;
    logic [15:0]              cfg_beats;
    logic [15:0]              line_off;
    logic [11:0]              cfg_lines;
    logic [11:0]              req_line;

    logic [CW-1:0]            outstanding;
    logic [CW-1:0]            stored;
    logic [CW-1:0]            ram_cnt;
    logic [g_BUFF_AWIDTH-1:0] wr_ptr;
    logic [g_BUFF_AWIDTH-1:0] rd_ptr;
    logic [g_BUFF_AWIDTH-1:0] rd_addr_q;
    logic                     rd_vld_q;
    logic                     rd_le_q;
    logic                     rd_fe_q;
    logic [15:0]              out_beat;
    logic [11:0]              out_line;

    logic                     skid_vld;
    logic [g_DWIDTH-1:0]      skid_data;
    logic                     skid_le;
    logic                     skid_fe;

    logic [g_DWIDTH-1:0]      mem [0:(2 ** g_BUFF_AWIDTH)-1];

    logic [15:0]              remain;
    logic [15:0]              len16;
    logic [CW-1:0]            credit;
    logic                     credit_ok;
    logic [g_DDR_AWIDTH-1:0]  addr_calc;
    logic                     acc;
    logic                     beat_ok;
    logic                     pop;
    logic                     fetch;
    logic [1:0]               load;
    logic                     start_ok;
    logic                     le_calc;
    logic                     fe_calc;
    logic [g_DWIDTH-1:0]      rd_word;

    always_comb begin
        remain    = cfg_beats - line_off;
        len16     = (remain >= BURST16) ? BURST16 : remain;
        credit    = DEPTH - (stored + outstanding);
        credit_ok = 32'(credit) >= 32'(len16);
        addr_calc = line_addr + g_DDR_AWIDTH'(line_off) * BEAT_BYTES;
        acc       = rd_req_o & rd_ack_i;
        beat_ok   = rd_data_valid_i & (outstanding != '0);
        pop       = pix_valid_o & pix_ready_i;
        start_ok  = (state == IDLE) & frame_start_i
                    & (line_beats_i != '0) & (frame_lines_i != '0);
        // Words already committed to the 2-entry output stage after this edge.
        load      = 2'(pix_valid_o) + 2'(skid_vld) + 2'(rd_vld_q) - 2'(pop);
        fetch     = (ram_cnt != '0) & (load < 2'd2);
        le_calc   = (out_beat == cfg_beats - 16'd1);
        fe_calc   = le_calc & (out_line == cfg_lines - 12'd1);
        rd_word   = mem[rd_addr_q];
    end

    always_ff @(posedge sys_clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            cfg_stride <= '0;
            cfg_beats  <= '0;
            cfg_lines  <= '0;
            line_addr  <= '0;
            line_off   <= '0;
            req_line   <= '0;
            rd_req_o   <= 1'b0;
            rd_addr_o  <= '0;
            rd_len_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        cfg_stride <= line_stride_i;
                        cfg_beats  <= line_beats_i;
                        cfg_lines  <= frame_lines_i;
                        line_addr  <= frame_base_addr_i;
                        line_off   <= '0;
                        req_line   <= '0;
                        busy_o     <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (acc) begin
                        rd_req_o <= 1'b0;
                        if (line_off + len16 == cfg_beats) begin
                            line_off  <= '0;
                            line_addr <= line_addr + cfg_stride;
                            if (req_line == cfg_lines - 12'd1) begin
                                state <= DRAIN;
                            end else begin
                                req_line <= req_line + 12'd1;
                            end
                        end else begin
                            line_off <= line_off + len16;
                        end
                    end else if (!rd_req_o && credit_ok) begin
                        rd_req_o  <= 1'b1;
                        rd_addr_o <= addr_calc;
                        rd_len_o  <= len16[8:0];
                    end
                end
                DRAIN: begin
                    if (pop && frame_end_o) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // stored covers RAM and output stage, so credit is only returned once a word leaves.
    always_ff @(posedge sys_clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            outstanding <= '0;
            stored      <= '0;
            ram_cnt     <= '0;
            wr_ptr      <= '0;
            ovf_err_o   <= 1'b0;
        end else begin
            outstanding <= outstanding + (acc ? CW'(rd_len_o) : '0) - CW'(beat_ok);
            stored      <= stored + CW'(beat_ok) - CW'(pop);
            ram_cnt     <= ram_cnt + CW'(beat_ok) - CW'(fetch);
            if (beat_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_data_valid_i && (outstanding == '0)) begin
                ovf_err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (beat_ok) begin
            mem[wr_ptr] <= rd_data_i;
        end
    end

    always_ff @(posedge sys_clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rd_ptr    <= '0;
            rd_addr_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_le_q   <= 1'b0;
            rd_fe_q   <= 1'b0;
            out_beat  <= '0;
            out_line  <= '0;
        end else begin
            rd_vld_q <= fetch;
            if (start_ok) begin
                out_beat <= '0;
                out_line <= '0;
            end else if (fetch) begin
                rd_addr_q <= rd_ptr;
                rd_ptr    <= rd_ptr + 1'b1;
                rd_le_q   <= le_calc;
                rd_fe_q   <= fe_calc;
                if (le_calc) begin
                    out_beat <= '0;
                    out_line <= out_line + 12'd1;
                end else begin
                    out_beat <= out_beat + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pix_valid_o <= 1'b0;
            pix_data_o  <= '0;
            line_end_o  <= 1'b0;
            frame_end_o <= 1'b0;
            skid_vld    <= 1'b0;
            skid_data   <= '0;
            skid_le     <= 1'b0;
            skid_fe     <= 1'b0;
        end else if (pop) begin
            if (skid_vld) begin
                pix_data_o  <= skid_data;
                line_end_o  <= skid_le;
                frame_end_o <= skid_fe;
                if (rd_vld_q) begin
                    skid_data <= rd_word;
                    skid_le   <= rd_le_q;
                    skid_fe   <= rd_fe_q;
                end else begin
                    skid_vld <= 1'b0;
                end
            end else if (rd_vld_q) begin
                pix_data_o  <= rd_word;
                line_end_o  <= rd_le_q;
                frame_end_o <= rd_fe_q;
            end else begin
                pix_valid_o <= 1'b0;
                line_end_o  <= 1'b0;
                frame_end_o <= 1'b0;
            end
        end else if (rd_vld_q) begin
            if (!pix_valid_o) begin
                pix_valid_o <= 1'b1;
                pix_data_o  <= rd_word;
                line_end_o  <= rd_le_q;
                frame_end_o <= rd_fe_q;
            end else begin
                skid_vld  <= 1'b1;
                skid_data <= rd_word;
                skid_le   <= rd_le_q;
                skid_fe   <= rd_fe_q;
            end
        end
    end

endmodule

// File: tb/tb_ddr_rd_line_fetch.sv
// Directed bench for ddr_rd_line_fetch with a small DDR responder and an in-order pixel/request model.
module tb_ddr_rd_line_fetch;

    logic        clk = 1'b0;
    logic        resetn_i;
    logic        frame_start_i;
    logic [31:0] frame_base_addr_i;
    logic [31:0] line_stride_i;
    logic [15:0] line_beats_i;
    logic [11:0] frame_lines_i;
    logic        rd_req_o;
    logic        rd_ack_i;
    logic [31:0] rd_addr_o;
    logic [8:0]  rd_len_o;
    logic        rd_data_valid_i;
    logic [63:0] rd_data_i;
    logic        pix_valid_o;
    logic        pix_ready_i;
    logic [63:0] pix_data_o;
    logic        line_end_o;
    logic        frame_end_o;
    logic        busy_o;
    logic        ovf_err_o;

    always #5 clk = ~clk;

    ddr_rd_line_fetch #(
        .g_BUFF_AWIDTH(5),
        .g_DWIDTH     (64),
        .g_DDR_AWIDTH (32),
        .g_BURST_LEN  (16)
    ) dut (
        .sys_clk_i        (clk),
        .resetn_i         (resetn_i),
        .frame_start_i    (frame_start_i),
        .frame_base_addr_i(frame_base_addr_i),
        .line_stride_i    (line_stride_i),
        .line_beats_i     (line_beats_i),
        .frame_lines_i    (frame_lines_i),
        .rd_req_o         (rd_req_o),
        .rd_ack_i         (rd_ack_i),
        .rd_addr_o        (rd_addr_o),
        .rd_len_o         (rd_len_o),
        .rd_data_valid_i  (rd_data_valid_i),
        .rd_data_i        (rd_data_i),
        .pix_valid_o      (pix_valid_o),
        .pix_ready_i      (pix_ready_i),
        .pix_data_o       (pix_data_o),
        .line_end_o       (line_end_o),
        .frame_end_o      (frame_end_o),
        .busy_o           (busy_o),
        .ovf_err_o        (ovf_err_o)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [31:0] f_base, f_stride;
    int          f_beats, f_lines;
    int          w_idx, le_cnt, fe_cnt, n_bursts, req_beats;
    int          rq_line, rq_off;
    int          cyc, first_beat_cyc, first_pix_cyc;
    bit          ack_rand, data_rand, ready_rand, ready_fix, inject;
    bit          rq_hold, px_hold;
    logic [31:0] hold_addr;
    logic [8:0]  hold_len;
    logic [63:0] hold_data;
    logic        hold_le, hold_fe;
    logic [31:0] beat_q[$];

    function automatic logic [63:0] fdata(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [31:0] stride,
                               input int beats, input int lines);
        f_base = base; f_stride = stride; f_beats = beats; f_lines = lines;
        w_idx = 0; le_cnt = 0; fe_cnt = 0; n_bursts = 0; req_beats = 0;
        rq_line = 0; rq_off = 0;
        frame_base_addr_i = base;
        line_stride_i     = stride;
        line_beats_i      = 16'(beats);
        frame_lines_i     = 12'(lines);
        frame_start_i     = 1'b1;
        tick();
        frame_start_i     = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        tick();
        while (busy_o && n < max_cyc) begin
            tick();
            n++;
        end
        chk("done_timeout", 64'(busy_o), 64'd0);
    endtask

    // DDR responder and downstream ready driver
    initial begin
        rd_ack_i = 1'b0; rd_data_valid_i = 1'b0; rd_data_i = '0; pix_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rd_ack_i    = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : ready_fix;
            if (inject) begin
                rd_data_valid_i = 1'b1;
                rd_data_i       = 64'hDEAD_BEEF_0BAD_F00D;
                inject          = 1'b0;
            end else if (beat_q.size() > 0 && (!data_rand || $urandom_range(0, 2) != 0)) begin
                rd_data_valid_i = 1'b1;
                rd_data_i       = fdata(beat_q.pop_front());
            end else begin
                rd_data_valid_i = 1'b0;
            end
        end
    end

    // Request and pixel monitor, sampled mid-cycle
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn_i) begin
                beat_q.delete();
                rq_hold = 1'b0;
                px_hold = 1'b0;
            end else begin
                if (rd_data_valid_i && first_beat_cyc == -1) first_beat_cyc = cyc;
                if (pix_valid_o && first_pix_cyc == -1) first_pix_cyc = cyc;
                if (rd_req_o) begin
                    if (rq_hold) begin
                        chk("req_addr_stable", 64'(rd_addr_o), 64'(hold_addr));
                        chk("req_len_stable", 64'(rd_len_o), 64'(hold_len));
                    end
                    if (rd_ack_i) begin
                        int rem;
                        logic [31:0] ea;
                        rem = f_beats - rq_off;
                        ea  = f_base + 32'(rq_line) * f_stride + 32'(rq_off * 8);
                        chk("req_addr", 64'(rd_addr_o), 64'(ea));
                        chk("req_len", 64'(rd_len_o), 64'(rem > 16 ? 16 : rem));
                        chk("req_credit", 64'(req_beats + int'(rd_len_o) - w_idx <= 32), 64'd1);
                        for (int i = 0; i < int'(rd_len_o); i++)
                            beat_q.push_back(rd_addr_o + 32'(i * 8));
                        req_beats += int'(rd_len_o);
                        n_bursts++;
                        rq_off += int'(rd_len_o);
                        if (rq_off >= f_beats) begin
                            rq_off = 0;
                            rq_line++;
                        end
                        rq_hold = 1'b0;
                    end else begin
                        rq_hold   = 1'b1;
                        hold_addr = rd_addr_o;
                        hold_len  = rd_len_o;
                    end
                end else begin
                    rq_hold = 1'b0;
                end
                if (pix_valid_o) begin
                    if (px_hold) begin
                        chk("pix_data_stable", pix_data_o, hold_data);
                        chk("line_end_stable", 64'(line_end_o), 64'(hold_le));
                        chk("frame_end_stable", 64'(frame_end_o), 64'(hold_fe));
                    end
                    if (pix_ready_i) begin
                        int ln, bt;
                        ln = w_idx / f_beats;
                        bt = w_idx % f_beats;
                        chk("pix_data", pix_data_o,
                            fdata(f_base + 32'(ln) * f_stride + 32'(bt * 8)));
                        chk("line_end", 64'(line_end_o), 64'(bt == f_beats - 1));
                        chk("frame_end", 64'(frame_end_o), 64'(w_idx == f_beats * f_lines - 1));
                        if (line_end_o) le_cnt++;
                        if (frame_end_o) fe_cnt++;
                        w_idx++;
                        px_hold = 1'b0;
                    end else begin
                        px_hold   = 1'b1;
                        hold_data = pix_data_o;
                        hold_le   = line_end_o;
                        hold_fe   = frame_end_o;
                    end
                end else begin
                    if (px_hold) chk("pix_valid_held", 64'(pix_valid_o), 64'd1);
                    px_hold = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w_before;
        resetn_i = 1'b0; frame_start_i = 1'b0; frame_base_addr_i = '0; line_stride_i = '0;
        line_beats_i = '0; frame_lines_i = '0;
        ack_rand = 1'b0; data_rand = 1'b0; ready_rand = 1'b0; ready_fix = 1'b1; inject = 1'b0;
        f_base = '0; f_stride = '0; f_beats = 1; f_lines = 1;
        w_idx = 0; req_beats = 0; n_bursts = 0; rq_line = 0; rq_off = 0;
        first_beat_cyc = 0; first_pix_cyc = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_req", 64'(rd_req_o), 64'd0);
        chk("rst_addr", 64'(rd_addr_o), 64'd0);
        chk("rst_len", 64'(rd_len_o), 64'd0);
        chk("rst_pix_valid", 64'(pix_valid_o), 64'd0);
        chk("rst_pix_data", pix_data_o, 64'd0);
        chk("rst_ovf", 64'(ovf_err_o), 64'd0);
        tick();
        resetn_i = 1'b1;
        repeat (2) tick();

        // 4 x 40 frame, ack and ready always high
        first_beat_cyc = -1; first_pix_cyc = -1;
        start_frame(32'h0000_0000, 32'h0000_2000, 40, 4);
        chk("busy_after_start", 64'(busy_o), 64'd1);
        wait_done(3000);
        chk("a_words", 64'(w_idx), 64'd160);
        chk("a_line_ends", 64'(le_cnt), 64'd4);
        chk("a_frame_ends", 64'(fe_cnt), 64'd1);
        chk("a_bursts", 64'(n_bursts), 64'd12);
        chk("a_latency", 64'(first_pix_cyc - first_beat_cyc), 64'd3);
        chk("a_ovf", 64'(ovf_err_o), 64'd0);
        first_beat_cyc = 0; first_pix_cyc = 0;

        // Backpressure: a 32-beat buffer caps requests while the sink stalls
        ready_fix = 1'b0;
        start_frame(32'h1000_0000, 32'h0000_0100, 40, 4);
        repeat (100) tick();
        chk("b_req_beats_capped", 64'(req_beats), 64'd32);
        chk("b_req_held_low", 64'(rd_req_o), 64'd0);
        chk("b_pix_valid", 64'(pix_valid_o), 64'd1);
        frame_base_addr_i = 32'h5555_0000; line_beats_i = 16'd1; frame_lines_i = 12'd1;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        repeat (3) tick();
        chk("b_busy_midstart", 64'(busy_o), 64'd1);
        chk("b_req_beats_midstart", 64'(req_beats), 64'd32);
        ready_fix = 1'b1;
        wait_done(3000);
        chk("b_words", 64'(w_idx), 64'd160);
        chk("b_bursts", 64'(n_bursts), 64'd12);
        chk("b_ovf", 64'(ovf_err_o), 64'd0);

        // Random stalls everywhere, address wraps inside line 0
        ack_rand = 1'b1; data_rand = 1'b1; ready_rand = 1'b1;
        start_frame(32'hFFFF_FFC0, 32'h0000_0800, 20, 3);
        wait_done(6000);
        ack_rand = 1'b0; data_rand = 1'b0; ready_rand = 1'b0;
        chk("c_words", 64'(w_idx), 64'd60);
        chk("c_line_ends", 64'(le_cnt), 64'd3);
        chk("c_frame_ends", 64'(fe_cnt), 64'd1);
        chk("c_bursts", 64'(n_bursts), 64'd6);
        chk("c_ovf", 64'(ovf_err_o), 64'd0);

        // Stray beat with nothing outstanding
        repeat (4) tick();
        w_before = w_idx;
        inject = 1'b1;
        repeat (8) tick();
        chk("ovf_set", 64'(ovf_err_o), 64'd1);
        chk("ovf_no_output", 64'(pix_valid_o), 64'd0);
        chk("ovf_words", 64'(w_idx), 64'(w_before));

        // Zero-config starts are ignored
        frame_base_addr_i = 32'h0; line_beats_i = 16'd40; frame_lines_i = 12'd0;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        repeat (3) tick();
        chk("zero_lines_busy", 64'(busy_o), 64'd0);
        chk("zero_lines_req", 64'(rd_req_o), 64'd0);
        line_beats_i = 16'd0; frame_lines_i = 12'd4;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        repeat (3) tick();
        chk("zero_beats_busy", 64'(busy_o), 64'd0);

        // Reset mid-frame, then a clean frame
        start_frame(32'h2000_0000, 32'h0000_0400, 40, 4);
        repeat (30) tick();
        chk("r_busy_before", 64'(busy_o), 64'd1);
        resetn_i = 1'b0;
        @(negedge clk);
        chk("r_busy", 64'(busy_o), 64'd0);
        chk("r_req", 64'(rd_req_o), 64'd0);
        chk("r_pix_valid", 64'(pix_valid_o), 64'd0);
        chk("r_pix_data", pix_data_o, 64'd0);
        chk("r_line_end", 64'(line_end_o), 64'd0);
        chk("r_frame_end", 64'(frame_end_o), 64'd0);
        chk("r_ovf", 64'(ovf_err_o), 64'd0);
        repeat (3) tick();
        resetn_i = 1'b1;
        repeat (2) tick();
        start_frame(32'h3000_0000, 32'h0000_2000, 40, 2);
        wait_done(3000);
        chk("r_words", 64'(w_idx), 64'd80);
        chk("r_frame_ends", 64'(fe_cnt), 64'd1);
        chk("r_ovf_after", 64'(ovf_err_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
